// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter
// Round-robin arbiter that owns the 2-bit select of the decoder/tri-state
// 4:1 bus. It grants one source at a time, bounds each tenure when others
// are waiting, and leaves the bus idle for a turnaround gap between owners
// so two tri-state drivers never drive the bus together.
module tristate_bus_arbiter #(
   parameter int MAX_HOLD    = 8,
   parameter int TURN_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [1:0] sel,
   output logic [3:0] gnt,
   output logic       bus_en,
   output logic       busy
);

   localparam int HW = $clog2(MAX_HOLD);
   localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
   localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [1:0]    last, last_nxt;
   logic [1:0]    sel_nxt;
   logic [HW-1:0] hold_cnt, hold_nxt;
   logic [TW-1:0] turn_cnt, turn_nxt;
   logic [3:0]    gnt_nxt;
   logic          bus_en_nxt;
   logic          busy_nxt;
   logic [1:0]    win;
   logic [1:0]    idx;
   logic [3:0]    others;
   logic          release_now;
   logic          expire_now;

   // Round-robin pick: scan last+1 .. last+4 (the last owner is scanned
   // last, so it has lowest priority); scanning backwards lets the
   // highest-priority hit overwrite the others.
   always_comb begin
      win = 2'd0;
      idx = 2'd0;
      for (int k = 4; k >= 1; k--) begin
         idx = last + 2'(k);
         if (req[idx]) begin
            win = idx;
         end
      end
   end

   // Tenure end conditions: the owner drops its request, or the hold
   // window is used up while somebody else is waiting.
   always_comb begin
      others      = req & ~(4'b0001 << sel);
      release_now = ~req[sel];
      expire_now  = (hold_cnt == HOLD_LAST) && (|others);
   end

   // Next-state logic; all outputs are computed from the next state so they
   // leave the flops glitch-free with no path from req to the pins.
   always_comb begin
      state_nxt = state;
      sel_nxt   = sel;
      last_nxt  = last;
      hold_nxt  = hold_cnt;
      turn_nxt  = turn_cnt;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = GRANT;
               sel_nxt   = win;
               last_nxt  = win;
               hold_nxt  = '0;
            end
         end
         GRANT: begin
            if (release_now || expire_now) begin
               state_nxt = TURN;
               turn_nxt  = '0;
            end else if (hold_cnt != HOLD_LAST) begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         TURN: begin
            if (turn_cnt == TURN_LAST) begin
               if (|req) begin
                  state_nxt = GRANT;
                  sel_nxt   = win;
                  last_nxt  = win;
                  hold_nxt  = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               turn_nxt = turn_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      gnt_nxt    = (state_nxt == GRANT) ? (4'b0001 << sel_nxt) : 4'b0000;
      bus_en_nxt = (state_nxt == GRANT);
      busy_nxt   = (state_nxt != IDLE);
   end

   // State, pointer, counters and registered outputs; reset clears the bus
   // immediately and restarts the pointer so source 0 is scanned first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= 2'd0;
         last     <= 2'd3;
         hold_cnt <= '0;
         turn_cnt <= '0;
         gnt      <= 4'b0000;
         bus_en   <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
         turn_cnt <= turn_nxt;
         gnt      <= gnt_nxt;
         bus_en   <= bus_en_nxt;
         busy     <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter
// Directed vectors for the round-robin tri-state bus arbiter plus
// hand-written multi-cycle sequences and a randomized invariant run.
module tb_tristate_bus_arbiter;

   localparam int MAX_HOLD    = 8;
   localparam int TURN_CYCLES = 1;
   localparam int MAX_WAIT    = 3 * (MAX_HOLD + TURN_CYCLES) + 1;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       bus_en;
   logic       busy;

   int checks;
   int fails;

   typedef struct {
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       en;
      logic       busy;
   } vec_t;

   vec_t tbl[11];

   tristate_bus_arbiter #(
      .MAX_HOLD(MAX_HOLD),
      .TURN_CYCLES(TURN_CYCLES)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req(req),
      .sel(sel),
      .gnt(gnt),
      .bus_en(bus_en),
      .busy(busy)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive req on the falling edge, then sample 1 unit after the rising edge
   task automatic applyStimulus(input logic [3:0] r);
      @(negedge clk);
      req = r;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] eg,
                              input logic [1:0] es, input logic ee,
                              input logic eb);
      checks += 4;
      if (gnt !== eg) begin
         fails++;
         $display("[TB] FAIL %s gnt: got %b want %b", name, gnt, eg);
      end
      if (sel !== es) begin
         fails++;
         $display("[TB] FAIL %s sel: got %0d want %0d", name, sel, es);
      end
      if (bus_en !== ee) begin
         fails++;
         $display("[TB] FAIL %s bus_en: got %b want %b", name, bus_en, ee);
      end
      if (busy !== eb) begin
         fails++;
         $display("[TB] FAIL %s busy: got %b want %b", name, busy, eb);
      end
   endtask

   task automatic checkBit(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         fails++;
         $display("[TB] FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   task automatic doReset();
      @(negedge clk);
      req   = 4'b0000;
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
   endtask

   // Main sequence
   initial begin : main
      logic [3:0] r;
      logic [3:0] prev_gnt;
      int         idle_run;
      bit         seen;
      int         wt[4];

      checks = 0;
      fails  = 0;

      // Single request, release, then pointer-driven arbitration
      tbl[0]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
      tbl[1]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
      tbl[2]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
      tbl[3]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1};
      tbl[4]  = '{4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0};
      tbl[5]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b1};
      tbl[6]  = '{4'b0001, 4'b0000, 2'd3, 1'b0, 1'b1};
      tbl[7]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
      tbl[8]  = '{4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1};
      tbl[9]  = '{4'b0110, 4'b0010, 2'd1, 1'b1, 1'b1};
      tbl[10] = '{4'b0100, 4'b0000, 2'd1, 1'b0, 1'b1};

      // Asynchronous reset with no clock edge yet, all sources requesting
      req   = 4'b1111;
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      #1;
      req   = 4'b0000;
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         applyStimulus(tbl[i].req);
         checkOutput($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].sel,
                     tbl[i].en, tbl[i].busy);
      end

      // Everybody requesting: 0,1,2,3,0 with MAX_HOLD cycles each and a gap
      doReset();
      for (int o = 0; o < 5; o++) begin
         for (int k = 0; k < MAX_HOLD; k++) begin
            applyStimulus(4'b1111);
            checkOutput($sformatf("rr_own%0d_c%0d", o, k),
                        4'b0001 << (o % 4), 2'(o % 4), 1'b1, 1'b1);
         end
         if (o < 4) begin
            applyStimulus(4'b1111);
            checkOutput($sformatf("rr_turn%0d", o), 4'b0000, 2'(o % 4),
                        1'b0, 1'b1);
         end
      end

      // Lone requester keeps the bus; a late arrival forces a handover
      doReset();
      for (int k = 0; k < 20; k++) begin
         applyStimulus(4'b0010);
         checkOutput($sformatf("lone_c%0d", k), 4'b0010, 2'd1, 1'b1, 1'b1);
      end
      applyStimulus(4'b1010);
      checkOutput("lone_exit", 4'b0000, 2'd1, 1'b0, 1'b1);
      applyStimulus(4'b1010);
      checkOutput("lone_next", 4'b1000, 2'd3, 1'b1, 1'b1);

      // Reset mid-tenure drops the bus at once and restarts the pointer
      doReset();
      applyStimulus(4'b0001);
      checkOutput("mid_own", 4'b0001, 2'd0, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      applyStimulus(4'b1001);
      checkOutput("mid_restart", 4'b0001, 2'd0, 1'b1, 1'b1);

      // Random traffic with invariant checks
      doReset();
      r        = 4'b0000;
      prev_gnt = 4'b0000;
      idle_run = 0;
      seen     = 1'b0;
      for (int i = 0; i < 4; i++) wt[i] = 0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(7) == 0) r[i] = ~r[i];
         end
         applyStimulus(r);
         checkBit("inv_onehot", $onehot0(gnt), 1'b1);
         checkBit("inv_bus_en", bus_en, |gnt);
         checkBit("inv_busy", busy | ~bus_en, 1'b1);
         if (gnt != 4'b0000) begin
            if (prev_gnt != 4'b0000) begin
               checkBit("inv_no_overlap", gnt == prev_gnt, 1'b1);
            end else if (seen) begin
               checkBit("inv_turn_gap", idle_run >= TURN_CYCLES, 1'b1);
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (r[i] && !gnt[i]) wt[i]++;
            else wt[i] = 0;
            checkBit($sformatf("inv_starve%0d", i), wt[i] <= MAX_WAIT, 1'b1);
         end
         if (gnt == 4'b0000) idle_run++;
         else idle_run = 0;
         if (gnt != 4'b0000) seen = 1'b1;
         prev_gnt = gnt;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
